hsv_match_ctrl: RTL

- Round controller that sequences the HSV similarity comparator for the colour-recognition game.
- On start it latches a target colour and difficulty, then drives the comparator's set-colour and threshold-level inputs.
- It waits out the comparator latency, then requires a sustained run of "similar" results before a timeout expires.
- It reports pass/fail per round and keeps a saturating score; it sits between the menu logic and the comparator.

---
 rtl/hsv_match_ctrl.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/hsv_match_ctrl.sv
// hsv_match_ctrl: round controller that drives the HSV similarity comparator.
// Latches target and difficulty on start, waits for the comparator to settle,
// then requires a run of HOLD_CYCLES "similar" flags before the timeout expires.
// Ports:
//   clk, rst              clock and synchronous active-high reset
//   start, abort          round control from the menu logic
//   target_h/s/v          target colour; difficulty 0 (easy) .. 3 (hardest)
//   similar_flag          comparator result (00 no, 01 yes, 1x not compared)
//   set_h/s/v             colour sent to the comparator
//   threshold_level       comparator threshold
//   busy, done            round active; one-cycle end-of-round pulse
//   pass, err             round result, held until the next start
//   hold_cnt, score       progress-bar count; saturating count of passed rounds
module hsv_match_ctrl #(
  parameter int HOLD_CYCLES    = 16,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int SETTLE_CYCLES  = 2,
  parameter int SCORE_W        = 8,
  localparam int HW = $clog2(HOLD_CYCLES + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [8:0]         target_h,
  input  logic [8:0]         target_s,
  input  logic [8:0]         target_v,
  input  logic [1:0]         difficulty,
  input  logic [1:0]         similar_flag,
  output logic [8:0]         set_h,
  output logic [8:0]         set_s,
  output logic [8:0]         set_v,
  output logic [2:0]         threshold_level,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic               err,
  output logic [HW-1:0]      hold_cnt,
  output logic [SCORE_W-1:0] score
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);

  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES);
  localparam logic [SW-1:0] SET_LAST  = SW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARM,
    S_TRACK,
    S_DONE
  } state_t;

  state_t        state;
  logic [TW-1:0] timer;
  logic [SW-1:0] settle;

  logic          bad_target;
  logic [2:0]    level;
  logic [HW-1:0] hold_inc;
  logic [TW-1:0] timer_inc;
  logic [SCORE_W-1:0] score_inc;

  // Zero target would leave the comparator idle forever; hue is 0..359.
  assign bad_target = (target_h > 9'd359) ||
                      ({target_h, target_s, target_v} == 27'd0);

  assign hold_inc  = hold_cnt + HW'(1);
  assign timer_inc = timer + TW'(1);
  assign score_inc = (&score) ? score : score + SCORE_W'(1);

  // Hardest level jumps to the tightest threshold rather than 3'b011.
  always_comb begin
    level = 3'b000;
    unique case (difficulty)
      2'd0: level = 3'b000;
      2'd1: level = 3'b001;
      2'd2: level = 3'b010;
      2'd3: level = 3'b111;
      default: level = 3'b000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_IDLE;
      timer           <= '0;
      settle          <= '0;
      set_h           <= '0;
      set_s           <= '0;
      set_v           <= '0;
      threshold_level <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      err             <= 1'b0;
      hold_cnt        <= '0;
      score           <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            pass     <= 1'b0;
            err      <= 1'b0;
            hold_cnt <= '0;
            timer    <= '0;
            settle   <= '0;
            if (bad_target) begin
              err   <= 1'b1;
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              set_h           <= target_h;
              set_s           <= target_s;
              set_v           <= target_v;
              threshold_level <= level;
              busy            <= 1'b1;
              state           <= S_ARM;
            end
          end
        end

        // Flags are ignored here while the comparator pipeline fills.
        S_ARM: begin
          if (abort) begin
            err   <= 1'b1;
            pass  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end else if (settle == SET_LAST) begin
            state <= S_TRACK;
          end else begin
            settle <= settle + SW'(1);
          end
        end

        // Priority: abort, protocol error, pass, timeout.
        S_TRACK: begin
          timer <= timer_inc;
          if (abort) begin
            err   <= 1'b1;
            pass  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end else if (similar_flag[1]) begin
            err   <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end else if (similar_flag[0] &&
                       hold_inc == HOLD_LAST) begin
            hold_cnt <= hold_inc;
            pass     <= 1'b1;
            score    <= score_inc;
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= S_DONE;
          end else begin
            hold_cnt <= similar_flag[0] ? hold_inc : '0;
            if (timer_inc == TMO_LAST) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= S_DONE;
            end
          end
        end

        // Zeroed set inputs park the comparator in "not compared".
        S_DONE: begin
          set_h           <= '0;
          set_s           <= '0;
          set_v           <= '0;
          threshold_level <= '0;
          state           <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
